// File: rtl/frt_multi_if.sv
// Register bus of the free-running timer: word address, write strobe, write data
// and combinational read data.
interface frt_multi_if;
    logic [3:0]  reg_a;
    logic [15:0] reg_di;
    logic        reg_we;
    logic [15:0] reg_do;

    modport master (output reg_a, output reg_di, output reg_we, input reg_do);
    modport slave  (input reg_a, input reg_di, input reg_we, output reg_do);
endinterface

// File: rtl/frt_multi.sv
// Free-running timer: prescaled counter with NUM_OC output-compare channels,
// overflow detection and one input-capture channel, all behind a word register bus.
module frt_multi #(
    parameter int               CNT_W    = 16,
    parameter int               NUM_OC   = 2,
    parameter logic [CNT_W-1:0] OCR_INIT = {CNT_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    frt_multi_if.slave        bus,
    input  logic              tclk,
    input  logic              fti,
    output logic [NUM_OC-1:0] fto,
    output logic              oci,
    output logic              ovi,
    output logic              ici
);

    localparam logic [3:0]       A_CTRL    = 4'd0;
    localparam logic [3:0]       A_STAT    = 4'd1;
    localparam logic [3:0]       A_FRC     = 4'd2;
    localparam logic [3:0]       A_FICR    = 4'd3;
    localparam logic [3:0]       A_OLVL    = 4'd4;
    localparam logic [7:0]       OC_MASK   = 8'((9'd1 << NUM_OC) - 9'd1);
    localparam logic [15:0]      CTRL_MASK = {8'h77, OC_MASK};
    localparam logic [CNT_W-1:0] FRC_MAX   = {CNT_W{1'b1}};

    logic [15:0]       ctrl_r;
    logic [CNT_W-1:0]  frc_r;
    logic [CNT_W-1:0]  ficr_r;
    logic [CNT_W-1:0]  ocr_r [NUM_OC];
    logic [NUM_OC-1:0] ocf_r;
    logic [NUM_OC-1:0] olvl_r;
    logic [NUM_OC-1:0] fto_r;
    logic              ovf_r;
    logic              icf_r;
    logic [6:0]        presc_r;
    logic [1:0]        tclk_sync_r;
    logic [1:0]        fti_sync_r;
    logic              tclk_d_r;
    logic              fti_d_r;

    logic              wr_ctrl_s;
    logic              wr_stat_s;
    logic              wr_frc_s;
    logic              wr_olvl_s;
    logic [NUM_OC-1:0] wr_ocr_s;
    logic [NUM_OC-1:0] match_s;
    logic [NUM_OC-1:0] ocf_set_s;
    logic [1:0]        cks_s;
    logic              cks_chg_s;
    logic              tclk_rise_s;
    logic              fti_edge_s;
    logic              presc_hit_s;
    logic              tick_s;
    logic              cnt_tick_s;
    logic              clr_s;
    logic              ovf_set_s;
    logic [CNT_W-1:0]  di_cnt_s;
    logic [15:0]       rd_s;

    function automatic logic [15:0] zext_cnt(input logic [CNT_W-1:0] v);
        logic [15:0] r;
        r = 16'h0000;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    function automatic logic [7:0] zext_oc(input logic [NUM_OC-1:0] v);
        logic [7:0] r;
        r = 8'h00;
        r[NUM_OC-1:0] = v;
        return r;
    endfunction

    assign cks_s       = ctrl_r[13:12];
    assign di_cnt_s    = bus.reg_di[CNT_W-1:0];
    assign wr_ctrl_s   = bus.reg_we && (bus.reg_a == A_CTRL);
    assign wr_stat_s   = bus.reg_we && (bus.reg_a == A_STAT);
    assign wr_frc_s    = bus.reg_we && (bus.reg_a == A_FRC);
    assign wr_olvl_s   = bus.reg_we && (bus.reg_a == A_OLVL);
    assign cks_chg_s   = wr_ctrl_s && (bus.reg_di[13:12] != cks_s);
    assign tclk_rise_s = tclk_sync_r[1] & ~tclk_d_r;
    assign fti_edge_s  = ctrl_r[14] ? (fti_sync_r[1] & ~fti_d_r) : (~fti_sync_r[1] & fti_d_r);

    // Tick source selection and per-channel compare/write decode.
    always_comb begin
        case (cks_s)
            2'd0:    presc_hit_s = (presc_r[2:0] == 3'b111);
            2'd1:    presc_hit_s = (presc_r[4:0] == 5'b11111);
            2'd2:    presc_hit_s = (presc_r == 7'b1111111);
            default: presc_hit_s = tclk_rise_s;
        endcase
        wr_ocr_s = '0;
        match_s  = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            wr_ocr_s[i] = bus.reg_we && (bus.reg_a == 4'(8 + i));
            match_s[i]  = (frc_r == ocr_r[i]);
        end
    end

    assign tick_s     = ce & presc_hit_s;
    // A CPU write to FRC suppresses every tick effect in that cycle.
    assign cnt_tick_s = tick_s & ~wr_frc_s;
    assign clr_s      = ctrl_r[10] & match_s[0];
    assign ovf_set_s  = cnt_tick_s & ~clr_s & (frc_r == FRC_MAX);
    assign ocf_set_s  = cnt_tick_s ? match_s : '0;

    // Read-data mux; unmapped addresses and bits above the field widths read 0.
    always_comb begin
        rd_s = 16'h0000;
        case (bus.reg_a)
            A_CTRL:  rd_s = ctrl_r;
            A_STAT:  rd_s = {6'b000000, icf_r, ovf_r, zext_oc(ocf_r)};
            A_FRC:   rd_s = zext_cnt(frc_r);
            A_FICR:  rd_s = zext_cnt(ficr_r);
            A_OLVL:  rd_s = {8'h00, zext_oc(olvl_r)};
            default: begin
                for (int i = 0; i < NUM_OC; i++) begin
                    if (bus.reg_a == 4'(8 + i)) begin
                        rd_s = zext_cnt(ocr_r[i]);
                    end else begin
                        rd_s = rd_s;
                    end
                end
            end
        endcase
    end

    assign bus.reg_do = rd_s;
    assign fto        = fto_r;
    assign oci        = |(ocf_r & ctrl_r[NUM_OC-1:0]);
    assign ovi        = ovf_r & ctrl_r[8];
    assign ici        = icf_r & ctrl_r[9];

    // All timer state: synchronizers, prescaler, registers, counter and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r      <= 16'h0000;
            frc_r       <= '0;
            ficr_r      <= '0;
            ocf_r       <= '0;
            olvl_r      <= '0;
            fto_r       <= '0;
            ovf_r       <= 1'b0;
            icf_r       <= 1'b0;
            presc_r     <= 7'd0;
            tclk_sync_r <= 2'b00;
            fti_sync_r  <= 2'b00;
            tclk_d_r    <= 1'b0;
            fti_d_r     <= 1'b0;
            for (int i = 0; i < NUM_OC; i++) begin
                ocr_r[i] <= OCR_INIT;
            end
        end else begin
            tclk_sync_r <= {tclk_sync_r[0], tclk};
            fti_sync_r  <= {fti_sync_r[0], fti};
            fti_d_r     <= fti_sync_r[1];
            // The TCLK edge flop only advances on CE cycles so an edge waits for one.
            if (ce) begin
                tclk_d_r <= tclk_sync_r[1];
            end
            if (cks_chg_s) begin
                presc_r <= 7'd0;
            end else if (ce) begin
                presc_r <= presc_r + 7'd1;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= bus.reg_di & CTRL_MASK;
            end
            if (wr_olvl_s) begin
                olvl_r <= bus.reg_di[NUM_OC-1:0];
            end
            for (int i = 0; i < NUM_OC; i++) begin
                if (wr_ocr_s[i]) begin
                    ocr_r[i] <= di_cnt_s;
                end
                if (ocf_set_s[i]) begin
                    fto_r[i] <= olvl_r[i];
                end
            end
            if (wr_frc_s) begin
                frc_r <= di_cnt_s;
            end else if (cnt_tick_s) begin
                frc_r <= clr_s ? '0 : frc_r + CNT_W'(1);
            end
            if (fti_edge_s) begin
                ficr_r <= frc_r;
            end
            // Hardware set beats a simultaneous CPU clear.
            ocf_r <= (wr_stat_s ? (ocf_r & bus.reg_di[NUM_OC-1:0]) : ocf_r) | ocf_set_s;
            ovf_r <= (wr_stat_s ? (ovf_r & bus.reg_di[8]) : ovf_r) | ovf_set_s;
            icf_r <= (wr_stat_s ? (icf_r & bus.reg_di[9]) : icf_r) | fti_edge_s;
        end
    end

endmodule

// File: tb/tb_frt_multi.sv
// Scoreboarded bench for frt_multi (CNT_W=12, NUM_OC=4) with directed scenarios
// followed by randomized register/pin traffic against a behavioural timer model.
module tb_frt_multi;
    localparam int W    = 12;
    localparam int N    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int OCM  = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst, ce, tclk, fti, rd_v;
    logic [N-1:0] fto;
    logic oci, ovi, ici;

    frt_multi_if bus();

    frt_multi #(.CNT_W(W), .NUM_OC(N)) dut (
        .clk(clk), .rst(rst), .ce(ce), .bus(bus), .tclk(tclk), .fti(fti),
        .fto(fto), .oci(oci), .ovi(ovi), .ici(ici)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int    exp_q[$];
    string nm_q[$];

    // Behavioural model state.
    int m_frc = 0, m_ficr = 0, m_ctrl = 0, m_ocf = 0, m_ovf = 0, m_icf = 0;
    int m_olvl = 0, m_fto = 0, m_cecnt = 0;
    int m_ocr[N];
    int th1 = 0, th2 = 0, tref = 0, fh1 = 0, fh2 = 0, fh3 = 0;

    function automatic int m_read(input int a);
        case (a)
            0: return m_ctrl;
            1: return (m_icf << 9) | (m_ovf << 8) | m_ocf;
            2: return m_frc;
            3: return m_ficr;
            4: return m_olvl;
            default: return (a >= 8 && a < 8 + N) ? m_ocr[a-8] : 0;
        endcase
    endfunction

    // Model: one step per clock, using inputs as presented at the rising edge.
    always @(posedge clk) begin
        int cks, period, wa, wd, nfrc, nfto, set_ocf, set_ovf;
        bit we, tick, trise, fedge;
        if (rst) begin
            m_frc = 0; m_ficr = 0; m_ctrl = 0; m_ocf = 0; m_ovf = 0; m_icf = 0;
            m_olvl = 0; m_fto = 0; m_cecnt = 0;
            th1 = 0; th2 = 0; tref = 0; fh1 = 0; fh2 = 0; fh3 = 0;
            for (int i = 0; i < N; i++) m_ocr[i] = MAXV;
        end else begin
            we = bus.reg_we; wa = int'(bus.reg_a); wd = int'(bus.reg_di);
            cks = (m_ctrl >> 12) & 3;
            period = (cks == 0) ? 8 : (cks == 1) ? 32 : 128;
            trise = (th2 == 1) && (tref == 0);
            fedge = ((m_ctrl >> 14) & 1) ? (fh2 == 1 && fh3 == 0) : (fh2 == 0 && fh3 == 1);
            tick = ce && ((cks == 3) ? trise : ((m_cecnt % period) == period - 1));
            set_ocf = 0; set_ovf = 0; nfrc = m_frc; nfto = m_fto;
            if (we && wa == 2) begin
                nfrc = wd & MAXV;
            end else if (tick) begin
                for (int i = 0; i < N; i++)
                    if (m_frc == m_ocr[i]) begin
                        set_ocf |= (1 << i);
                        nfto = (nfto & ~(1 << i)) | (m_olvl & (1 << i));
                    end
                if (((m_ctrl >> 10) & 1) == 1 && m_frc == m_ocr[0]) nfrc = 0;
                else if (m_frc == MAXV) begin nfrc = 0; set_ovf = 1; end
                else nfrc = m_frc + 1;
            end
            if (fedge) m_ficr = m_frc;
            if (we && wa == 1) begin
                m_ocf &= wd; m_ovf &= (wd >> 8) & 1; m_icf &= (wd >> 9) & 1;
            end
            m_ocf |= set_ocf; m_ovf |= set_ovf;
            if (fedge) m_icf = 1;
            if (we && wa == 0 && ((wd >> 12) & 3) != cks) m_cecnt = 0;
            else if (ce) m_cecnt = (m_cecnt + 1) % 128;
            if (we && wa == 0) m_ctrl = wd & (16'h7700 | OCM);
            if (we && wa == 4) m_olvl = wd & OCM;
            if (we && wa >= 8 && wa < 8 + N) m_ocr[wa-8] = wd & MAXV;
            m_frc = nfrc; m_fto = nfto;
            if (ce) tref = th2;
            th2 = th1; th1 = int'(tclk);
            fh3 = fh2; fh2 = fh1; fh1 = int'(fti);
        end
    end

    // Monitor: pops the scoreboard on every presented read and checks the pins each cycle.
    always @(negedge clk) begin
        int e;
        string nm;
        logic [N+2:0] pe;
        #2;
        if (rd_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_underflow a=%0d got=%h required=<queued value>", bus.reg_a, bus.reg_do);
            end else begin
                e = exp_q.pop_front(); nm = nm_q.pop_front();
                if (bus.reg_do !== 16'(e)) begin
                    failures++;
                    $display("FAIL %s a=%0d got=%h required=%h", nm, bus.reg_a, bus.reg_do, 16'(e));
                end
            end
        end
        pe = {N'(m_fto), ((m_ocf & m_ctrl & OCM) != 0), (m_ovf == 1 && ((m_ctrl >> 8) & 1) == 1),
              (m_icf == 1 && ((m_ctrl >> 9) & 1) == 1)};
        checks++;
        if ({fto, oci, ovi, ici} !== pe) begin
            failures++;
            $display("FAIL pins t=%0t got fto/oci/ovi/ici=%b required=%b", $time, {fto, oci, ovi, ici}, pe);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); bus.reg_we = 1'b0; rd_v = 1'b0; end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk); rd_v = 1'b0; bus.reg_we = 1'b1; bus.reg_a = 4'(a); bus.reg_di = 16'(d);
    endtask

    task automatic rd(input int a, input string nm);
        @(negedge clk); bus.reg_we = 1'b0; bus.reg_a = 4'(a); rd_v = 1'b1;
        exp_q.push_back(m_read(a)); nm_q.push_back(nm);
    endtask

    task automatic rd_const(input int a, input int e, input string nm);
        @(negedge clk); bus.reg_we = 1'b0; bus.reg_a = 4'(a); rd_v = 1'b1;
        exp_q.push_back(e); nm_q.push_back(nm);
    endtask

    initial begin
        int r, a, d;
        rst = 1'b1; ce = 1'b0; tclk = 1'b0; fti = 1'b0; rd_v = 1'b0;
        bus.reg_we = 1'b0; bus.reg_a = 4'd0; bus.reg_di = 16'h0000;
        idle(3);
        rst = 1'b0;
        // Reset state.
        rd_const(0, 0, "ctrl_rst"); rd_const(1, 0, "stat_rst"); rd_const(2, 0, "frc_rst");
        rd_const(3, 0, "ficr_rst"); rd_const(4, 0, "olvl_rst"); rd_const(8, MAXV, "ocr0_rst");
        rd_const(11, MAXV, "ocr3_rst"); rd_const(12, 0, "unmapped_ocr"); rd_const(5, 0, "unmapped5");
        // Divide-by-8 counting.
        idle(1); ce = 1'b1;
        idle(7); rd_const(2, 1, "frc_after8");
        idle(7); rd_const(2, 2, "frc_after16");
        // Compare-clear on channel 0.
        idle(1); ce = 1'b0;
        wr(8, 5); wr(4, 1); wr(2, 0); wr(1, 0); wr(0, 16'h0401);
        idle(1); ce = 1'b1;
        for (int k = 0; k < 16; k++) begin rd(2, "frc_cclr"); rd(1, "stat_cclr"); idle(2); end
        // Overflow and flag clear.
        idle(1); ce = 1'b0;
        wr(0, 16'h0100); wr(2, MAXV); wr(1, 0);
        idle(1); ce = 1'b1;
        idle(7); rd_const(2, 0, "frc_wrap");
        rd_const(1, 16'h010E, "stat_ovf");
        wr(1, 0); rd_const(1, 0, "stat_cleared");
        // Input capture on rising FTI with the counter held.
        wr(0, 16'h7200); wr(2, 16'h1234);
        rd_const(2, 16'h0234, "frc_trunc");
        idle(1); fti = 1'b1;
        rd_const(3, 0, "ficr_lat1"); rd_const(3, 0, "ficr_lat2"); rd_const(3, 16'h0234, "ficr_cap");
        rd_const(1, 16'h0200, "stat_icf");
        wr(1, 0); idle(1); fti = 1'b0; idle(6);
        rd_const(3, 16'h0234, "ficr_fall_hold"); rd_const(1, 0, "stat_fall_noicf");
        // CPU write to FRC in a tick cycle; OVF clear in an overflow cycle.
        idle(1); tclk = 1'b1; idle(1); wr(2, 16'h0100); rd_const(2, 16'h0100, "frc_wr_prio");
        idle(1); tclk = 1'b0; idle(4); wr(2, MAXV);
        idle(1); tclk = 1'b1; idle(1); wr(1, 0);
        rd_const(1, 16'h010E, "ovf_set_wins"); rd_const(2, 0, "frc_tclk_wrap");
        idle(1); tclk = 1'b0;
        // Distinct compare values on channels 1..3, then wrap at 12 bits.
        wr(0, 16'h000F); wr(9, 3); wr(10, 7); wr(11, 10); wr(4, 16'h000E); wr(2, 0); wr(1, 0);
        for (int k = 0; k < 14; k++) begin rd(1, "stat_multi"); rd(2, "frc_multi"); idle(6); end
        wr(2, 16'h0FF0);
        for (int k = 0; k < 20; k++) begin rd(2, "frc_w12"); rd(1, "stat_w12"); idle(6); end
        // Randomized traffic.
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            bus.reg_we = 1'b0; rd_v = 1'b0;
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) tclk = ~tclk;
            if ($urandom_range(0, 15) == 0) fti = ~fti;
            rst = ($urandom_range(0, 599) == 0);
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            if (r < 2) begin
                d = $urandom_range(0, 16'hFFFF);
                if (a == 0 && $urandom_range(0, 3) != 0) d = d & 16'h47FF;
                if ((a == 2 || a >= 8) && $urandom_range(0, 3) != 0) d = $urandom_range(0, 40);
                if (a == 2 && $urandom_range(0, 3) == 0) d = MAXV - $urandom_range(0, 3);
                bus.reg_we = 1'b1; bus.reg_a = 4'(a); bus.reg_di = 16'(d);
            end else if (r < 6) begin
                bus.reg_a = 4'(a); rd_v = 1'b1;
                exp_q.push_back(m_read(a)); nm_q.push_back("rand_rd");
            end
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
